// File: rtl/cp0_compare_timer_pkg.sv
// Shared constants and helpers for the CP0 Compare / timer-interrupt block.
package cp0_compare_timer_pkg;

  // CP0 address of the Compare register.
  localparam logic [5:0]  CP0ADDR_COMPARE = 6'd11;
  // Compare value loaded at reset.
  localparam logic [31:0] COMPARE_INI     = 32'h0000_0000;
  // Bit positions of the timer flag inside the Cause register.
  localparam int          CAUSE_TI_BIT    = 30;
  localparam int          CAUSE_IP7_BIT   = 15;

  // A pending timer interrupt reaches the core only when interrupts are
  // globally enabled, the core is not already in exception level, and
  // hardware interrupt line 7 is unmasked.
  function automatic logic timer_irq_qual(input logic ti, input logic ie,
                                          input logic exl, input logic im7);
    return ti & ie & ~exl & im7;
  endfunction

endpackage

// File: rtl/cp0_compare_timer_if.sv
// Signal bundle between the CP0 top level and the Compare/timer block.
// There is no handshake on this bus: mtc0_we is a single-cycle write
// strobe that is acted on at the edge where it is sampled high, and every
// other input is a level that is sampled at each rising clock edge.
interface cp0_compare_timer_if;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic [31:0] count_data;
  logic        status_ie;
  logic        status_exl;
  logic        status_im7;
  logic [31:0] compare_data;
  logic        cause_ti;
  logic        timer_irq;

  // CP0 top level / pipeline side.
  modport master (
    output mtc0_we, cp0_addr, mtc0_data, count_data,
           status_ie, status_exl, status_im7,
    input  compare_data, cause_ti, timer_irq
  );

  // Compare/timer block side.
  modport slave (
    input  mtc0_we, cp0_addr, mtc0_data, count_data,
           status_ie, status_exl, status_im7,
    output compare_data, cause_ti, timer_irq
  );
endinterface

// File: rtl/cp0_compare_timer.sv
// CP0 Compare register and timer-interrupt source. Watches Count and sets
// Cause.TI when Count changes to a value equal to Compare; TI is sticky
// until Compare is written. timer_irq is a registered, Status-qualified
// copy of TI.
module cp0_compare_timer
  import cp0_compare_timer_pkg::*;
#(
  parameter logic [31:0] COMPARE_INI_P  = COMPARE_INI,
  parameter logic [5:0]  ADDR_COMPARE_P = CP0ADDR_COMPARE
) (
  input logic                    clk,
  input logic                    rst_n,
  cp0_compare_timer_if.slave     bus
);

  logic [31:0] compare_q;
  logic [31:0] count_prev_q;
  logic        ti_q;
  logic        irq_q;

  logic compare_we;
  logic count_changed;
  logic match;

  // Compare write decode, Count change detect and full-width match against
  // the registered Compare value.
  always_comb begin
    compare_we    = bus.mtc0_we && (bus.cp0_addr == ADDR_COMPARE_P);
    count_changed = (bus.count_data != count_prev_q);
    match         = count_changed && (bus.count_data == compare_q);
  end

  // State update. A Compare write beats a coincident match, so writing
  // Compare always leaves TI clear. count_prev is loaded from Count even in
  // reset so that no spurious change is seen on the first active cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      compare_q    <= COMPARE_INI_P;
      count_prev_q <= bus.count_data;
      ti_q         <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      count_prev_q <= bus.count_data;
      if (compare_we) begin
        compare_q <= bus.mtc0_data;
        ti_q      <= 1'b0;
      end else if (match) begin
        ti_q      <= 1'b1;
      end
      irq_q <= timer_irq_qual(ti_q, bus.status_ie, bus.status_exl, bus.status_im7);
    end
  end

  // Register outputs straight to the bus.
  always_comb begin
    bus.compare_data = compare_q;
    bus.cause_ti     = ti_q;
    bus.timer_irq    = irq_q;
  end

endmodule

// File: tb/tb_cp0_compare_timer.sv
// Testbench for cp0_compare_timer: directed scenarios followed by random
// traffic, with a cycle model feeding an expected-value queue.
module tb_cp0_compare_timer;

  localparam int W = 34;  // {compare_data, cause_ti, timer_irq}

  logic clk;
  logic rst_n;
  cp0_compare_timer_if bus ();

  cp0_compare_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_cmp, m_prev;
  logic        m_ti, m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently on the bus.
  task automatic model_step();
    logic wr, chg, hit;
    logic [31:0] n_cmp;
    logic        n_ti, n_irq;
    if (!rst_n) begin
      n_cmp = 32'h0; n_ti = 1'b0; n_irq = 1'b0;
    end else begin
      wr    = bus.mtc0_we && (bus.cp0_addr == 6'd11);
      chg   = (bus.count_data != m_prev);
      hit   = chg && (bus.count_data == m_cmp);
      n_cmp = wr ? bus.mtc0_data : m_cmp;
      n_ti  = wr ? 1'b0 : (m_ti | hit);
      n_irq = m_ti & bus.status_ie & ~bus.status_exl & bus.status_im7;
    end
    m_prev = bus.count_data;
    m_cmp  = n_cmp;
    m_ti   = n_ti;
    m_irq  = n_irq;
    exp_q.push_back({m_cmp, m_ti, m_irq});
  endtask

  // One clock: push expectation, wait for the edge, sample #1 later.
  task automatic cycle();
    logic [W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_compare", bus.compare_data, e[33:2]);
      check("sb_ti",      {31'd0, bus.cause_ti},  {31'd0, e[1]});
      check("sb_irq",     {31'd0, bus.timer_irq}, {31'd0, e[0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mtc0_write(input logic [5:0] addr, input logic [31:0] data);
    bus.mtc0_we = 1'b1; bus.cp0_addr = addr; bus.mtc0_data = data;
    cycle();
    bus.mtc0_we = 1'b0;
  endtask

  task automatic set_count(input logic [31:0] v);
    bus.count_data = v;
    cycle();
  endtask

  task automatic set_qual(input logic ie, input logic exl, input logic im7);
    bus.status_ie = ie; bus.status_exl = exl; bus.status_im7 = im7;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.mtc0_we = 1'b0; bus.cp0_addr = 6'd0; bus.mtc0_data = 32'h0;
    bus.count_data = 32'd5;
    set_qual(1'b0, 1'b0, 1'b0);
    m_cmp = 32'h0; m_prev = 32'h0; m_ti = 1'b0; m_irq = 1'b0;
    @(negedge clk);

    // T1: reset
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    check("t1_compare", bus.compare_data, 32'd0);
    check("t1_ti",      {31'd0, bus.cause_ti},  32'd0);
    check("t1_irq",     {31'd0, bus.timer_irq}, 32'd0);

    // T2: basic match
    mtc0_write(6'd11, 32'd10);
    check("t2_compare", bus.compare_data, 32'd10);
    set_qual(1'b1, 1'b0, 1'b1);
    set_count(32'd8);
    set_count(32'd9);
    check("t2_ti_before", {31'd0, bus.cause_ti}, 32'd0);
    set_count(32'd10);
    check("t2_ti",        {31'd0, bus.cause_ti},  32'd1);
    check("t2_irq_lag",   {31'd0, bus.timer_irq}, 32'd0);
    cycle();
    check("t2_irq",       {31'd0, bus.timer_irq}, 32'd1);
    mtc0_write(6'd12, 32'd99);  // other address: no effect
    check("t2_other_cmp", bus.compare_data, 32'd10);
    check("t2_other_ti",  {31'd0, bus.cause_ti}, 32'd1);

    // T3: clear on write, then re-arm
    mtc0_write(6'd11, 32'd20);
    check("t3_ti_clr",  {31'd0, bus.cause_ti},  32'd0);
    cycle();
    check("t3_irq_clr", {31'd0, bus.timer_irq}, 32'd0);
    set_count(32'd20);
    check("t3_ti_again", {31'd0, bus.cause_ti}, 32'd1);

    // T4: write/match collision
    mtc0_write(6'd11, 32'd30);
    bus.count_data = 32'd30;
    mtc0_write(6'd11, 32'd40);
    check("t4_ti",      {31'd0, bus.cause_ti}, 32'd0);
    check("t4_compare", bus.compare_data, 32'd40);
    cycle();
    check("t4_steady",  {31'd0, bus.cause_ti}, 32'd0);

    // T5: wrap-around and steady Count
    mtc0_write(6'd11, 32'd0);
    set_count(32'hFFFF_FFFF);
    set_count(32'd0);
    check("t5_wrap_ti", {31'd0, bus.cause_ti}, 32'd1);
    mtc0_write(6'd11, 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    check("t5_steady_ti", {31'd0, bus.cause_ti}, 32'd0);

    // T6: qualifiers and reset
    set_qual(1'b1, 1'b1, 1'b1);
    mtc0_write(6'd11, 32'd50);
    set_count(32'd50);
    check("t6_ti", {31'd0, bus.cause_ti}, 32'd1);
    cycle(); cycle();
    check("t6_irq_exl", {31'd0, bus.timer_irq}, 32'd0);
    set_qual(1'b1, 1'b0, 1'b1);
    cycle();
    check("t6_irq_on", {31'd0, bus.timer_irq}, 32'd1);
    rst_n = 1'b0;
    cycle();
    check("t6_rst_cmp", bus.compare_data, 32'd0);
    check("t6_rst_ti",  {31'd0, bus.cause_ti},  32'd0);
    check("t6_rst_irq", {31'd0, bus.timer_irq}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Random traffic: small Count range to make matches frequent.
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(0, 49) != 0);
      bus.mtc0_we    = ($urandom_range(0, 5) == 0);
      bus.cp0_addr   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd11;
      bus.mtc0_data  = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) bus.count_data = 32'($urandom_range(0, 7));
      set_qual(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      cycle();
    end
    bus.mtc0_we = 1'b0;
    rst_n = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
